vga_timing_gen: RTL and testbench

Pixel-timing generator for the 640x480 @ 60 Hz display path. It runs on the 25 MHz pixel clock and produces the raster coordinates (DrawX, DrawY), the display-enable flag (blank) and the horizontal/vertical sync pulses. The menu renderer and other sprite stages consume DrawX, DrawY and blank directly, and the monitor pins take hs/vs. It also provides line/frame strobes and a frame counter for animation and menu logic.

---
 rtl/vga_timing_gen.sv | 92 +++++++++
 tb/tb_vga_timing_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel/line counters plus registered
// blank, sync, strobe and frame-count outputs aligned to DrawX/DrawY.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // 11-bit bounds so a sync end of exactly 1024 still compares correctly
  localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic        h_wrap;
  logic        v_wrap;
  logic [9:0]  nx;
  logic [9:0]  ny;
  logic [10:0] nx_w;
  logic [10:0] ny_w;
  logic        n_blank;
  logic        n_hs;
  logic        n_vs;

  always_comb begin
    h_wrap = (DrawX == H_LAST);
    v_wrap = (DrawY == V_LAST);
    nx     = h_wrap ? 10'd0 : DrawX + 10'd1;
    ny     = DrawY;
    if (h_wrap) begin
      ny = v_wrap ? 10'd0 : DrawY + 10'd1;
    end
    nx_w    = {1'b0, nx};
    ny_w    = {1'b0, ny};
    n_blank = (nx_w < H_VIS) && (ny_w < V_VIS);
    n_hs    = !((nx_w >= HS_BEG) && (nx_w < HS_END));
    n_vs    = !((ny_w >= VS_BEG) && (ny_w < VS_END));
  end

  assign sync = 1'b0;

  // Flags decode the next-state counters so they land with them.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b1;
      hs          <= 1'b1;
      vs          <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= nx;
      DrawY       <= ny;
      blank       <= n_blank;
      hs          <= n_hs;
      vs          <= n_vs;
      line_start  <= (nx == 10'd0);
      frame_start <= (nx == 10'd0) && (ny == 10'd0);
      if (h_wrap && v_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, shrunken-frame and
// narrow-line instances on one pixel clock.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  logic rst2 = 1'b0;

  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic b0, h0, v0, s0, l0, f0;
  logic b1, h1, v1, s1, l1, f1;
  logic b2, h2, v2, s2, l2, f2;
  logic [7:0] c0, c1, c2;

  int tests = 0;
  int fails = 0;

  int ex1 = 0;
  int ey1 = 0;
  int fc1 = 0;

  vga_timing_gen d0 (
    .vga_clk(clk), .reset_n(rst0), .DrawX(x0), .DrawY(y0),
    .blank(b0), .hs(h0), .vs(v0), .sync(s0),
    .line_start(l0), .frame_start(f0), .frame_count(c0)
  );

  // 16x8 raster: hs at x 10..12, vs at y 5..6, 128-cycle frame
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) d1 (
    .vga_clk(clk), .reset_n(rst1), .DrawX(x1), .DrawY(y1),
    .blank(b1), .hs(h1), .vs(v1), .sync(s1),
    .line_start(l1), .frame_start(f1), .frame_count(c1)
  );

  vga_timing_gen #(
    .H_VISIBLE(320), .H_FRONT(8), .H_SYNC(48), .H_BACK(24)
  ) d2 (
    .vga_clk(clk), .reset_n(rst2), .DrawX(x2), .DrawY(y2),
    .blank(b2), .hs(h2), .vs(v2), .sync(s2),
    .line_start(l2), .frame_start(f2), .frame_count(c2)
  );

  task automatic test_reset;
    rst0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({x0, y0, b0, h0, v0, s0, l0, f0, c0} !==
          {10'd0, 10'd0, 6'b111010, 8'd0}) begin
        fails++;
        $display("FAIL reset c%0d: x=%0d y=%0d b=%b hs=%b vs=%b sy=%b ls=%b fs=%b fc=%0d want 0 0 1 1 1 0 1 0 0",
                 i, x0, y0, b0, h0, v0, s0, l0, f0, c0);
      end
    end
    rst0 = 1'b1;
    @(negedge clk);
    tests++;
    if (x0 !== 10'd1 || y0 !== 10'd0 || l0 !== 1'b0 || f0 !== 1'b0) begin
      fails++;
      $display("FAIL release: x=%0d y=%0d ls=%b fs=%b want 1 0 0 0",
               x0, y0, l0, f0);
    end
  endtask

  task automatic test_hline;
    int ex = 1;
    int ey = 0;
    int hsl = 0;
    int lsn = 0;
    logic eb, eh;
    repeat (801) begin
      @(negedge clk);
      if (ex == 799) begin
        ex = 0;
        ey++;
      end else ex++;
      eb = (ex < 640) && (ey < 480);
      eh = !(ex >= 656 && ex < 752);
      tests++;
      if (x0 !== 10'(ex) || y0 !== 10'(ey) || b0 !== eb || h0 !== eh ||
          v0 !== 1'b1 || l0 !== (ex == 0) || f0 !== 1'b0 || s0 !== 1'b0) begin
        fails++;
        $display("FAIL hline: x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b want x=%0d y=%0d b=%b hs=%b",
                 x0, y0, b0, h0, v0, l0, f0, ex, ey, eb, eh);
      end
      if (!h0 && ey == 0) hsl++;
      if (l0) lsn++;
    end
    tests++;
    if (hsl != 96 || lsn != 1 || y0 !== 10'd1 || x0 !== 10'd2) begin
      fails++;
      $display("FAIL hline_totals: hs_low=%0d ls=%0d x=%0d y=%0d want 96 1 2 1",
               hsl, lsn, x0, y0);
    end
  endtask

  task automatic test_mid_reset;
    int n = 0;
    while (x0 !== 10'd700 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (x0 !== 10'd700 || y0 !== 10'd1) begin
      fails++;
      $display("FAIL mid_reach: x=%0d y=%0d want 700 1", x0, y0);
    end
    rst0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    tests++;
    if ({x0, y0, b0, h0, v0, s0, l0, f0, c0} !==
        {10'd0, 10'd0, 6'b111010, 8'd0}) begin
      fails++;
      $display("FAIL mid_reset: x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
               x0, y0, b0, h0, v0, l0, f0, c0);
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      tests++;
      if (x0 !== 10'(i) || y0 !== 10'd0 || f0 !== 1'b0 || l0 !== 1'b0) begin
        fails++;
        $display("FAIL mid_restart: x=%0d y=%0d fs=%b ls=%b want x=%0d y=0",
                 x0, y0, f0, l0, i);
      end
    end
  endtask

  task automatic step_small;
    if (ex1 == 15) begin
      ex1 = 0;
      if (ey1 == 7) begin
        ey1 = 0;
        fc1 = (fc1 + 1) % 256;
      end else ey1++;
    end else ex1++;
  endtask

  task automatic test_full_frame;
    int vsl = 0;
    int lsn = 0;
    int fsn = 0;
    logic eb, eh, ev;
    rst1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    tests++;
    if (x1 !== 10'd0 || y1 !== 10'd0 || c1 !== 8'd0 || f1 !== 1'b0 ||
        l1 !== 1'b1 || b1 !== 1'b1 || h1 !== 1'b1 || v1 !== 1'b1) begin
      fails++;
      $display("FAIL small_reset: x=%0d y=%0d fc=%0d fs=%b ls=%b",
               x1, y1, c1, f1, l1);
    end
    ex1 = 0;
    ey1 = 0;
    fc1 = 0;
    for (int cyc = 1; cyc <= 128; cyc++) begin
      @(negedge clk);
      step_small();
      eb = (ex1 < 8) && (ey1 < 4);
      eh = !(ex1 >= 10 && ex1 < 13);
      ev = !(ey1 >= 5 && ey1 < 7);
      tests++;
      if (x1 !== 10'(ex1) || y1 !== 10'(ey1) || b1 !== eb || h1 !== eh ||
          v1 !== ev || l1 !== (ex1 == 0) || s1 !== 1'b0 ||
          f1 !== (ex1 == 0 && ey1 == 0) || c1 !== 8'(fc1)) begin
        fails++;
        $display("FAIL frame c%0d: x=%0d y=%0d b=%b hs=%b vs=%b ls=%b fs=%b fc=%0d want %0d %0d %b %b %b",
                 cyc, x1, y1, b1, h1, v1, l1, f1, c1, ex1, ey1, eb, eh, ev);
      end
      if (!v1) vsl++;
      if (l1) lsn++;
      if (f1) fsn++;
    end
    tests++;
    if (vsl != 32 || lsn != 8 || fsn != 1 || f1 !== 1'b1 || c1 !== 8'd1) begin
      fails++;
      $display("FAIL frame_totals: vs_low=%0d ls=%0d fs=%0d fs_end=%b fc=%0d want 32 8 1 1 1",
               vsl, lsn, fsn, f1, c1);
    end
  endtask

  task automatic test_frame_wrap;
    logic seen255 = 1'b0;
    int nerr = 0;
    repeat (255 * 128) begin
      @(negedge clk);
      step_small();
      if (c1 === 8'd255) seen255 = 1'b1;
      tests++;
      if (x1 !== 10'(ex1) || y1 !== 10'(ey1) || c1 !== 8'(fc1) ||
          f1 !== (ex1 == 0 && ey1 == 0)) begin
        fails++;
        nerr++;
        if (nerr <= 10)
          $display("FAIL wrap: x=%0d y=%0d fs=%b fc=%0d want %0d %0d fc=%0d",
                   x1, y1, f1, c1, ex1, ey1, fc1);
      end
    end
    tests++;
    if (!seen255 || c1 !== 8'd0 || f1 !== 1'b1) begin
      fails++;
      $display("FAIL wrap_end: seen255=%b fc=%0d fs=%b want 1 0 1",
               seen255, c1, f1);
    end
  endtask

  task automatic test_param_override;
    int ex = 0;
    int ey = 0;
    int hsl = 0;
    int lsn = 0;
    logic eb, eh;
    rst2 = 1'b0;
    @(negedge clk);
    rst2 = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (ex == 399) begin
        ex = 0;
        ey++;
      end else ex++;
      eb = (ex < 320);
      eh = !(ex >= 328 && ex < 376);
      tests++;
      if (x2 !== 10'(ex) || y2 !== 10'(ey) || b2 !== eb || h2 !== eh ||
          v2 !== 1'b1 || l2 !== (ex == 0) || f2 !== 1'b0 || s2 !== 1'b0) begin
        fails++;
        $display("FAIL narrow: x=%0d y=%0d b=%b hs=%b ls=%b want %0d %0d %b %b",
                 x2, y2, b2, h2, l2, ex, ey, eb, eh);
      end
      if (!h2) hsl++;
      if (l2) lsn++;
    end
    tests++;
    if (hsl != 48 || lsn != 1 || x2 !== 10'd0 || y2 !== 10'd1 ||
        c2 !== 8'd0) begin
      fails++;
      $display("FAIL narrow_totals: hs_low=%0d ls=%0d x=%0d y=%0d fc=%0d want 48 1 0 1 0",
               hsl, lsn, x2, y2, c2);
    end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_mid_reset();
    test_full_frame();
    test_frame_wrap();
    test_param_override();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
